cella_cmd_seq: RTL and testbench



---
 rtl/cella_pkg.sv | 45 ++++
 rtl/cella_cmd_seq_if.sv | 48 ++++
 rtl/cella_rsp_fifo.sv | 45 ++++
 rtl/cella_cmd_seq.sv | 161 ++++++++++++++++
 tb/tb_cella_cmd_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cella_pkg.sv
// Shared types, default geometry and address helpers for the CELLA command sequencer.
package cella_pkg;

    localparam int unsigned NUM_BANKS_DEF = 16;
    localparam int unsigned NUM_ROWS_DEF  = 4;
    localparam int unsigned NUM_COLS_DEF  = 8;
    localparam int unsigned WORD_W_DEF    = 16;
    localparam int unsigned RD_LAT_DEF    = 1;
    localparam int unsigned RSP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SEARCH = 2'b10,
        OP_NOP    = 2'b11
    } op_e;

    // On the command side the NOP encoding means sweep-search.
    localparam op_e CMD_SWEEP = OP_NOP;

    typedef enum logic {
        S_IDLE,
        S_SWEEP
    } state_e;

    function automatic logic [31:0] addr_col(input logic [31:0] addr, input int unsigned col_w);
        return addr & ((32'd1 << col_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_line(input logic [31:0] addr, input int unsigned col_w);
        return addr >> col_w;
    endfunction

    function automatic logic [31:0] addr_join(input logic [31:0] line, input logic [31:0] col,
                                              input int unsigned col_w);
        return (line << col_w) | col;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n = 0;
        for (int i = 0; i < 64; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/cella_cmd_seq_if.sv
// Command, array and response signals of the sequencer; rsp_cnt exists only with CELLA_SEQ_POPCNT_EN.
interface cella_cmd_seq_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned COL_W  = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WORD_W-1:0] cmd_bank;
    logic              cmd_en;

    logic [1:0]        arr_op_code;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_data_bank;
    logic [WORD_W-1:0] arr_data_in;
    logic [WORD_W-1:0] arr_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_data;
    logic [COL_W-1:0]  rsp_col;
    logic              rsp_last;
`ifdef CELLA_SEQ_POPCNT_EN
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    logic [CNT_W-1:0]  rsp_cnt;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_bank, cmd_en, arr_rdata, rsp_ready,
        input  cmd_ready, arr_op_code, arr_addr, arr_data_bank, arr_data_in,
               rsp_valid, rsp_data, rsp_col, rsp_last
`ifdef CELLA_SEQ_POPCNT_EN
        , input rsp_cnt
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_bank, cmd_en, arr_rdata, rsp_ready,
        output cmd_ready, arr_op_code, arr_addr, arr_data_bank, arr_data_in,
               rsp_valid, rsp_data, rsp_col, rsp_last
`ifdef CELLA_SEQ_POPCNT_EN
        , output rsp_cnt
`endif
    );

endinterface

// File: rtl/cella_rsp_fifo.sv
// Show-ahead response FIFO: head entry is visible whenever valid_o is high; flush empties it.
module cella_rsp_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         valid_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    // NOTE: storage has no reset; cnt_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o   = (cnt_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/cella_cmd_seq.sv
// CELLA command sequencer: one array op per cycle, sweep-search over all columns, credit-limited responses.
// Define CELLA_SEQ_POPCNT_EN to add rsp_cnt (popcount of rsp_data, captured at FIFO push).
module cella_cmd_seq
    import cella_pkg::*;
#(
    parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
    parameter int unsigned NUM_ROWS  = NUM_ROWS_DEF,
    parameter int unsigned NUM_COLS  = NUM_COLS_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned RD_LAT    = RD_LAT_DEF,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cella_cmd_seq_if.slave bus
);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
    localparam int unsigned COL_W  = $clog2(NUM_COLS);
    localparam int unsigned LINE_W = BANK_W + ROW_W;
    localparam int unsigned ADDR_W = LINE_W + COL_W;
    localparam int unsigned CRD_W  = $clog2(RSP_DEPTH + 1);
`ifdef CELLA_SEQ_POPCNT_EN
    localparam int unsigned CNT_W  = $clog2(WORD_W + 1);
    localparam int unsigned ENT_W  = WORD_W + COL_W + 1 + CNT_W;
`else
    localparam int unsigned ENT_W  = WORD_W + COL_W + 1;
`endif

    typedef struct packed {
        logic             vld;
        logic [COL_W-1:0] col;
        logic             last;
    } tag_t;

    state_e            state_q;
    logic [COL_W-1:0]  col_cnt_q;
    logic [LINE_W-1:0] swp_line_q;
    logic [WORD_W-1:0] swp_mask_q;
    logic              swp_en_q;
    logic [CRD_W-1:0]  credit_q, credit_d;
    op_e               arr_op_q;
    logic [ADDR_W-1:0] arr_addr_q;
    logic [WORD_W-1:0] arr_bank_q;
    logic              arr_en_q;
    tag_t              iss_q;
    tag_t              pipe_q [RD_LAT];

    logic has_credit, cmd_ready, accept, issue, pop, rsp_valid;
    logic [ENT_W-1:0] push_ent, head_ent;

    assign has_credit = (credit_q < CRD_W'(RSP_DEPTH));
    assign cmd_ready  = !rst && (state_q == S_IDLE) && has_credit;
    assign accept     = bus.cmd_valid && cmd_ready;
    assign pop        = rsp_valid && bus.rsp_ready;

    // NOTE: always_comb outputs get a default first so no path can leave a latch behind.
    always_comb begin
        issue = 1'b0;
        if (state_q == S_SWEEP)
            issue = has_credit;
        else if (accept)
            issue = (bus.cmd_op == OP_READ) || (bus.cmd_op == OP_SEARCH);
        credit_d = credit_q + CRD_W'(issue) - CRD_W'(pop);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_cnt_q  <= '0;
            swp_line_q <= '0;
            swp_mask_q <= '0;
            swp_en_q   <= 1'b0;
            credit_q   <= '0;
            arr_op_q   <= OP_NOP;
            arr_addr_q <= '0;
            arr_bank_q <= '0;
            arr_en_q   <= 1'b0;
            iss_q      <= '0;
        end else begin
            credit_q   <= credit_d;
            arr_op_q   <= OP_NOP;
            arr_addr_q <= '0;
            arr_bank_q <= '0;
            arr_en_q   <= 1'b0;
            iss_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept && bus.cmd_op == CMD_SWEEP) begin
                        state_q    <= S_SWEEP;
                        col_cnt_q  <= '0;
                        swp_line_q <= LINE_W'(addr_line(32'(bus.cmd_addr), COL_W));
                        swp_mask_q <= bus.cmd_bank;
                        swp_en_q   <= bus.cmd_en;
                    end else if (accept) begin
                        arr_op_q   <= op_e'(bus.cmd_op);
                        arr_addr_q <= bus.cmd_addr;
                        arr_bank_q <= bus.cmd_bank;
                        arr_en_q   <= bus.cmd_en;
                        iss_q      <= tag_t'{vld: (bus.cmd_op != OP_WRITE), col: '0, last: 1'b1};
                    end
                end
                S_SWEEP: begin
                    if (has_credit) begin
                        arr_op_q   <= OP_SEARCH;
                        arr_addr_q <= ADDR_W'(addr_join(32'(swp_line_q), 32'(col_cnt_q), COL_W));
                        arr_bank_q <= swp_mask_q;
                        arr_en_q   <= swp_en_q;
                        iss_q      <= tag_t'{vld: 1'b1, col: col_cnt_q,
                                             last: (col_cnt_q == COL_W'(NUM_COLS - 1))};
                        col_cnt_q  <= col_cnt_q + 1'b1;
                        if (col_cnt_q == COL_W'(NUM_COLS - 1)) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // iss_q travels with the driven op; RD_LAT more stages line it up with arr_rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= iss_q;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

`ifdef CELLA_SEQ_POPCNT_EN
    assign push_ent = {bus.arr_rdata, pipe_q[RD_LAT-1].col, pipe_q[RD_LAT-1].last,
                       CNT_W'(popcount(64'(bus.arr_rdata)))};
    assign {bus.rsp_data, bus.rsp_col, bus.rsp_last, bus.rsp_cnt} = head_ent;
`else
    assign push_ent = {bus.arr_rdata, pipe_q[RD_LAT-1].col, pipe_q[RD_LAT-1].last};
    assign {bus.rsp_data, bus.rsp_col, bus.rsp_last} = head_ent;
`endif

    cella_rsp_fifo #(
        .W     (ENT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (1'b0),
        .push_i      (pipe_q[RD_LAT-1].vld),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .rd_data_o   (head_ent),
        .valid_o     (rsp_valid)
    );

    assign bus.cmd_ready     = cmd_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.arr_op_code   = arr_op_q;
    assign bus.arr_addr      = arr_addr_q;
    assign bus.arr_data_bank = arr_bank_q;
    assign bus.arr_data_in   = {{(WORD_W-1){1'b0}}, arr_en_q};

endmodule

// File: tb/tb_cella_cmd_seq.sv
// Directed bench for cella_cmd_seq with a one-cycle-latency array model (RD_LAT=1).
// With CELLA_SEQ_POPCNT_EN defined the rsp_cnt output is also checked.
module tb_cella_cmd_seq;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cella_cmd_seq_if #(.ADDR_W(9), .WORD_W(16), .COL_W(3)) bus ();

    cella_cmd_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: one word per {bank,row}; read = word ^ mask, search = (word ^ query) + col.
    logic [15:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    always @(posedge clk) begin
        case (bus.arr_op_code)
            2'b01: begin
                mem[bus.arr_addr[8:3]] <= bus.arr_data_bank;
                bus.arr_rdata <= 16'h0000;
            end
            2'b00: bus.arr_rdata <= bus.arr_data_in[0] ? (mem[bus.arr_addr[8:3]] ^ bus.arr_data_bank)
                                                       : 16'h0000;
            2'b10: bus.arr_rdata <= bus.arr_data_in[0]
                                  ? ((mem[bus.arr_addr[8:3]] ^ bus.arr_data_bank) + 16'(bus.arr_addr[2:0]))
                                  : 16'h0000;
            default: bus.arr_rdata <= 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single cycle; returns in the cycle after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] bank,
                        input logic en);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_bank  = bank;
        bus.cmd_en    = en;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_col;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_bank  = '0;
        bus.cmd_en    = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_op",    32'(bus.arr_op_code), 32'h3);
        check("rst_addr",  32'(bus.arr_addr), 32'h0);
        check("rst_ready", 32'(bus.cmd_ready), 32'h0);
        check("rst_rspv",  32'(bus.rsp_valid), 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.cmd_ready), 32'h1);

        // Write 0x00FF to bank0/row0: one cycle on the array, no response
        send(2'b01, 9'd0, 16'h00FF, 1'b0);
        check("wr_op",   32'(bus.arr_op_code), 32'h1);
        check("wr_bank", 32'(bus.arr_data_bank), 32'h00FF);
        tick();
        check("wr_nop_op",   32'(bus.arr_op_code), 32'h3);
        check("wr_nop_bank", 32'(bus.arr_data_bank), 32'h0);
        tick();
        check("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);

        // Read addr 0, mask 0, en=1: response at accept+3
        send(2'b00, 9'd0, 16'h0000, 1'b1);
        check("rd_op",      32'(bus.arr_op_code), 32'h0);
        check("rd_din",     32'(bus.arr_data_in), 32'h1);
        check("rd_rspv_n1", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("rd_rspv_n2", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("rd_rspv_n3", 32'(bus.rsp_valid), 32'h1);
        check("rd_data",    32'(bus.rsp_data), 32'h00FF);
        check("rd_last",    32'(bus.rsp_last), 32'h1);
        check("rd_col",     32'(bus.rsp_col), 32'h0);
        tick();
        check("rd_rspv_n4", 32'(bus.rsp_valid), 32'h0);

        // Read with invert mask 0x0001: mask on the bus for exactly one cycle
        send(2'b00, 9'd0, 16'h0001, 1'b1);
        check("rdm_bank_n1", 32'(bus.arr_data_bank), 32'h0001);
        tick();
        check("rdm_bank_n2", 32'(bus.arr_data_bank), 32'h0000);
        tick();
        check("rdm_rspv", 32'(bus.rsp_valid), 32'h1);
        check("rdm_data", 32'(bus.rsp_data), 32'h00FE);
        tick();

        // Single search at col 5: result 0x00AA+5, but rsp_col stays 0
        send(2'b10, 9'd5, 16'h0055, 1'b1);
        check("srch_op",   32'(bus.arr_op_code), 32'h2);
        check("srch_addr", 32'(bus.arr_addr), 32'h5);
        tick();
        tick();
        check("srch_rspv", 32'(bus.rsp_valid), 32'h1);
        check("srch_data", 32'(bus.rsp_data), 32'h00AF);
        check("srch_col",  32'(bus.rsp_col), 32'h0);
        check("srch_last", 32'(bus.rsp_last), 32'h1);
        tick();

        // Search at col 0 returning 0x00AA (popcount 4)
        send(2'b10, 9'd0, 16'h0055, 1'b1);
        tick();
        tick();
        check("pc_rspv", 32'(bus.rsp_valid), 32'h1);
        check("pc_data", 32'(bus.rsp_data), 32'h00AA);
`ifdef CELLA_SEQ_POPCNT_EN
        check("pc_cnt",  32'(bus.rsp_cnt), 32'h4);
`endif
        tick();

        // Sweep, rsp_ready=1: cols 0..7 on consecutive cycles, responses follow two cycles later
        send(2'b11, 9'd0, 16'h0000, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k != 1) tick();
            if (k >= 2 && k <= 9) begin
                check("sw1_op",  32'(bus.arr_op_code), 32'h2);
                check("sw1_col", 32'(bus.arr_addr[2:0]), 32'(k - 2));
            end else begin
                check("sw1_nop", 32'(bus.arr_op_code), 32'h3);
            end
            check("sw1_ready", 32'(bus.cmd_ready), 32'(k >= 9));
            if (k >= 4 && k <= 11) begin
                check("sw1_rspv", 32'(bus.rsp_valid), 32'h1);
                check("sw1_rcol", 32'(bus.rsp_col), 32'(k - 4));
                check("sw1_data", 32'(bus.rsp_data), 32'h00FF + 32'(k - 4));
                check("sw1_last", 32'(bus.rsp_last), 32'(k == 11));
            end else begin
                check("sw1_rspv_n", 32'(bus.rsp_valid), 32'h0);
            end
        end

        // Sweep with rsp_ready=0: four searches, stall, then resume at col 4
        bus.rsp_ready = 1'b0;
        send(2'b11, 9'd0, 16'h0000, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            if (k != 1) tick();
            if (k >= 2 && k <= 5) begin
                check("sw2_op",  32'(bus.arr_op_code), 32'h2);
                check("sw2_col", 32'(bus.arr_addr[2:0]), 32'(k - 2));
            end else if (k >= 9 && k <= 12) begin
                check("sw2_op",  32'(bus.arr_op_code), 32'h2);
                check("sw2_col", 32'(bus.arr_addr[2:0]), 32'(k - 5));
            end else begin
                check("sw2_nop", 32'(bus.arr_op_code), 32'h3);
            end
            check("sw2_ready", 32'(bus.cmd_ready), 32'(k >= 12));
            if (k >= 4 && k <= 14) begin
                exp_col = (k <= 7) ? 32'h0 : 32'(k - 7);
                check("sw2_rspv", 32'(bus.rsp_valid), 32'h1);
                check("sw2_rcol", 32'(bus.rsp_col), exp_col);
                check("sw2_data", 32'(bus.rsp_data), 32'h00FF + exp_col);
                check("sw2_last", 32'(bus.rsp_last), 32'(exp_col == 32'd7));
            end else begin
                check("sw2_rspv_n", 32'(bus.rsp_valid), 32'h0);
            end
            if (k == 7) bus.rsp_ready = 1'b1;
        end

        // Back-to-back reads with rsp_ready=0: four accepts, then cmd_ready drops
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 9'd0;
        bus.cmd_bank  = 16'h0000;
        bus.cmd_en    = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("b2b_ready_full", 32'(bus.cmd_ready), 32'h0);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b_rspv", 32'(bus.rsp_valid), 32'h1);
            check("b2b_data", 32'(bus.rsp_data), 32'h00FF);
            tick();
        end
        check("b2b_drained", 32'(bus.rsp_valid), 32'h0);
        check("b2b_ready",   32'(bus.cmd_ready), 32'h1);

        // Reset while sweep col 3 is on the array
        send(2'b11, 9'd0, 16'h0000, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check("rs_col3", 32'(bus.arr_addr[2:0]), 32'h3);
        check("rs_rspv_pre", 32'(bus.rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("rs_op",    32'(bus.arr_op_code), 32'h3);
        check("rs_rspv",  32'(bus.rsp_valid), 32'h0);
        check("rs_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("rs_op_rel",   32'(bus.arr_op_code), 32'h3);
        check("rs_rspv_rel", 32'(bus.rsp_valid), 32'h0);
        send(2'b00, 9'd0, 16'h0000, 1'b1);
        check("rs_rd_rspv_n1", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("rs_rd_rspv_n2", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("rs_rd_rspv", 32'(bus.rsp_valid), 32'h1);
        check("rs_rd_data", 32'(bus.rsp_data), 32'h00FF);
        check("rs_rd_last", 32'(bus.rsp_last), 32'h1);
        tick();
        check("rs_rd_done", 32'(bus.rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
